oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA controller: the bus initiator that feeds the PPU's CPU-side register interface. A CPU write to $4014 halts the CPU, takes ownership of the CPU bus, and copies 256 bytes from CPU page $XX00-$XXFF into PPU register $2004 (OAMDATA) as alternating read/write bus cycles. It sits between the CPU core and the CPU address decoder, beside ppu_top, and runs on the 25 MHz pixel clock using the CPU-cycle enable.

## Interface
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer
- OAM_REG_ADDR, 16'h2004, destination register address
- clk  in  1  25 MHz system clock; all logic on posedge
- rstn_in  in  1  asynchronous, active-low reset
- cpu_ce  in  1  one-clk strobe marking the end of each CPU cycle (from ph2_falling)
- cpu_addr  in  16  CPU core address
- cpu_rnw  in  1  CPU core read-not-write
- cpu_dout  in  8  CPU core write data
- cpu_halted  in  1  CPU core has stopped on RDY (current cycle is a halted read)
- cpu_rdy  out  1  1 = CPU may run; 0 = halt request
- bus_own  out  1  1 = bus_* drive the shared CPU bus (address-decoder mux select)
- bus_addr  out  16  DMA address
- bus_rnw  out  1  DMA read-not-write
- bus_dout  out  8  DMA write data
- bus_din  in  8  shared-bus read data, valid at the cpu_ce that ends a read cycle
- dma_active  out  1  transfer in progress (HALT through last WRITE)

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE. Transitions only on clk edges with cpu_ce=1; otherwise all registers hold.
- parity flop: toggles on every cpu_ce, 0 after reset; cycle "even" when parity=0.
- IDLE: cpu_ce & cpu_addr==DMA_REG_ADDR & !cpu_rnw -> latch page=cpu_dout, idx=0, cpu_rdy<=0, dma_active<=1, -> HALT.
- HALT: wait for cpu_halted=1 at cpu_ce; then -> READ if next cycle is even, else -> ALIGN. bus_own<=1 on leaving HALT.
- ALIGN: one idle cycle (bus_rnw=1, bus_addr=held) -> READ.
- READ: bus_addr={page,idx}, bus_rnw=1; at ending cpu_ce latch data<=bus_din -> WRITE.
- WRITE: bus_addr=OAM_REG_ADDR, bus_rnw=0, bus_dout=data; at ending cpu_ce idx<=idx+1; idx==255 -> IDLE with cpu_rdy<=1, bus_own<=0, dma_active<=0; else -> READ.
- idx is 8 bits; address never carries into page ($FF page reads $FF00-$FFFF).
- Writes to DMA_REG_ADDR while not IDLE are ignored (CPU is halted; bus_own masks its address).
- Reset values: state=IDLE, cpu_rdy=1, bus_own=0, dma_active=0, bus_addr=0, bus_rnw=1, bus_dout=0, page=0, idx=0, parity=0.
- Reset mid-transfer: immediate return to reset values; partial OAM contents left as written.

## Timing
- All outputs registered; they change only on the clk edge carrying cpu_ce and stay stable for the whole following CPU cycle.
- cpu_rdy falls on the same edge that accepts the $4014 write.
- Transfer length after the trigger cycle: 1 HALT + 0/1 ALIGN + 512 = 513 (even) or 514 (odd) CPU cycles, given cpu_halted already 1 in HALT; each extra HALT wait adds one cycle (parity rechecked on exit).
- cpu_rdy returns to 1 on the edge ending the 256th WRITE; bus_own drops on that same edge.
- No combinational path from any input to any output.

## Structure
- Shared include nes_defines.vh: PPU/APU register addresses ($2000-$2007, $4014), state encoding localparams (3-bit).
- Single module; no sub-module. Target 150-250 lines.

## Test plan
- Trigger: write $02 to $4014 on an even cycle, cpu_halted=1 -> cpu_rdy=0 next edge, no ALIGN, bus reads $0200..$02FF alternating with writes to $2004, 513 CPU cycles total, cpu_rdy=1 after.
- Odd alignment: same trigger one cycle later -> exactly one ALIGN cycle, 514 total, first READ on even parity.
- Data path: memory model with mem[$0300+i]=i^$A5, page $03 -> 256 writes to $2004 with bus_dout=i^$A5 in order.
- Wrap: page $FF -> last read address $FFFF, next write to $2004, then IDLE; no $0000 access.
- Slow halt: hold cpu_halted=0 for 3 cpu_ce after trigger -> bus_own stays 0, no reads until cpu_halted=1, then normal transfer.
- Reset at idx=$40 during WRITE: rstn_in low -> cpu_rdy=1, bus_own=0, dma_active=0 asynchronously; new $4014 write afterwards starts at idx=0.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared constants and state encoding for the OAM DMA controller.
package oam_dma_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // CPU register addresses seen on the shared bus
  localparam logic [ADDR_W-1:0] DMA_REG_ADDR = 16'h4014;
  localparam logic [ADDR_W-1:0] OAM_REG_ADDR = 16'h2004;

  // Transfer sequencer states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: halts the CPU and copies one 256-byte page into OAMDATA,
// alternating READ/WRITE bus cycles paced by the CPU-cycle enable.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rstn_in,
  input  logic              cpu_ce,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rnw,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_halted,
  output logic              cpu_rdy,
  output logic              bus_own,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rnw,
  output logic [DATA_W-1:0] bus_dout,
  input  logic [DATA_W-1:0] bus_din,
  output logic              dma_active
);

  dma_state_e        state_q, state_d;
  logic              parity_q, parity_d;
  logic [DATA_W-1:0] page_q, page_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        idx_inc;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              bus_own_q, bus_own_d;
  logic              dma_active_q, dma_active_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_rnw_q, bus_rnw_d;
  logic [DATA_W-1:0] bus_dout_q, bus_dout_d;

  // Byte index within the page; wraps in 8 bits so the page never carries
  assign idx_inc = idx_q + 8'd1;

  // Next-state and next-output logic; everything holds between CPU cycles
  always_comb begin
    state_d      = state_q;
    parity_d     = parity_q;
    page_d       = page_q;
    idx_d        = idx_q;
    cpu_rdy_d    = cpu_rdy_q;
    bus_own_d    = bus_own_q;
    dma_active_d = dma_active_q;
    bus_addr_d   = bus_addr_q;
    bus_rnw_d    = bus_rnw_q;
    bus_dout_d   = bus_dout_q;

    if (cpu_ce) begin
      parity_d = ~parity_q;
      case (state_q)
        ST_IDLE: begin
          if ((cpu_addr == DMA_REG_ADDR) && !cpu_rnw) begin
            page_d       = cpu_dout;
            idx_d        = 8'd0;
            cpu_rdy_d    = 1'b0;
            dma_active_d = 1'b1;
            state_d      = ST_HALT;
          end
        end
        ST_HALT: begin
          // parity_q=1 now means the next cycle is even, so reads can start
          if (cpu_halted) begin
            bus_own_d = 1'b1;
            bus_rnw_d = 1'b1;
            if (parity_q) begin
              bus_addr_d = {page_q, idx_q};
              state_d    = ST_READ;
            end else begin
              state_d    = ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          bus_addr_d = {page_q, idx_q};
          bus_rnw_d  = 1'b1;
          state_d    = ST_READ;
        end
        ST_READ: begin
          bus_dout_d = bus_din;
          bus_addr_d = OAM_REG_ADDR;
          bus_rnw_d  = 1'b0;
          state_d    = ST_WRITE;
        end
        ST_WRITE: begin
          idx_d     = idx_inc;
          bus_rnw_d = 1'b1;
          if (idx_q == 8'hFF) begin
            cpu_rdy_d    = 1'b1;
            bus_own_d    = 1'b0;
            dma_active_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            bus_addr_d = {page_q, idx_inc};
            state_d    = ST_READ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q      <= ST_IDLE;
      parity_q     <= 1'b0;
      page_q       <= '0;
      idx_q        <= '0;
      cpu_rdy_q    <= 1'b1;
      bus_own_q    <= 1'b0;
      dma_active_q <= 1'b0;
      bus_addr_q   <= '0;
      bus_rnw_q    <= 1'b1;
      bus_dout_q   <= '0;
    end else begin
      state_q      <= state_d;
      parity_q     <= parity_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      cpu_rdy_q    <= cpu_rdy_d;
      bus_own_q    <= bus_own_d;
      dma_active_q <= dma_active_d;
      bus_addr_q   <= bus_addr_d;
      bus_rnw_q    <= bus_rnw_d;
      bus_dout_q   <= bus_dout_d;
    end
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign bus_own    = bus_own_q;
  assign dma_active = dma_active_q;
  assign bus_addr   = bus_addr_q;
  assign bus_rnw    = bus_rnw_q;
  assign bus_dout   = bus_dout_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: CPU cycle = 3 clocks, memory model on bus_din.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rstn_in;
  logic        cpu_ce = 1'b0;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_dout;
  logic        cpu_halted;
  logic        cpu_rdy;
  logic        bus_own;
  logic [15:0] bus_addr;
  logic        bus_rnw;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        dma_active;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_cnt   = 0;
  logic tb_par = 1'b0;

  oam_dma dut (
    .clk        (clk),
    .rstn_in    (rstn_in),
    .cpu_ce     (cpu_ce),
    .cpu_addr   (cpu_addr),
    .cpu_rnw    (cpu_rnw),
    .cpu_dout   (cpu_dout),
    .cpu_halted (cpu_halted),
    .cpu_rdy    (cpu_rdy),
    .bus_own    (bus_own),
    .bus_addr   (bus_addr),
    .bus_rnw    (bus_rnw),
    .bus_dout   (bus_dout),
    .bus_din    (bus_din),
    .dma_active (dma_active)
  );

  always #20 clk = ~clk;

  // cpu_ce: one clock in three, changed on the falling edge
  always @(negedge clk) begin
    ce_cnt = (ce_cnt == 2) ? 0 : ce_cnt + 1;
    cpu_ce = (ce_cnt == 2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Page $03 holds i^$A5; other pages a different pattern so page errors show
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a[15:8] == 8'h03) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Advance to just after the next clock edge that carries cpu_ce
  task automatic cpu_cycle();
    do @(posedge clk); while (cpu_ce !== 1'b1);
    #1;
    tb_par = ~tb_par;
  endtask

  task automatic run_xfer(input string nm, input logic [7:0] page, input logic trig_par,
                          input int delay, input int exp_cycles, input int exp_align,
                          input logic poke);
    int rd_idx = 0;
    int wr_idx = 0;
    int n = 0;
    int aligns = 0;
    int halt_extra = 0;
    int seq_err = 0;
    int first_par = -1;
    logic [15:0] last_rd = 16'h0;
    logic done = 1'b0;

    if (tb_par != trig_par) cpu_cycle();
    cpu_addr = 16'h4014; cpu_rnw = 1'b0; cpu_dout = page; cpu_halted = 1'b0;
    cpu_cycle();
    check({nm, "_trig_rdy"}, cpu_rdy, 0);
    check({nm, "_trig_active"}, dma_active, 1);
    check({nm, "_trig_own"}, bus_own, 0);
    cpu_addr = 16'h0000; cpu_rnw = 1'b1;
    if (poke) begin
      cpu_addr = 16'h4014; cpu_rnw = 1'b0; cpu_dout = 8'h11;
    end

    for (int k = 1; k <= 700 && !done; k++) begin
      cpu_halted = (k - 1 >= delay);
      bus_din = (bus_own && bus_rnw) ? mem_rd(bus_addr) : 8'h00;
      cpu_cycle();
      if (cpu_rdy) begin
        done = 1'b1;
        n = k;
      end else if (!bus_own) begin
        halt_extra++;
      end else if (bus_rnw) begin
        if (rd_idx < 256 && bus_addr == {page, 8'(rd_idx)}) begin
          if (rd_idx != wr_idx) seq_err++;
          if (rd_idx == 0) first_par = int'(tb_par);
          last_rd = bus_addr;
          rd_idx++;
        end else begin
          aligns++;
        end
      end else begin
        if (bus_addr != 16'h2004 || wr_idx != rd_idx - 1 ||
            bus_dout != mem_rd({page, 8'(wr_idx)})) seq_err++;
        wr_idx++;
      end
    end
    cpu_addr = 16'h0000; cpu_rnw = 1'b1; cpu_halted = 1'b0;

    check({nm, "_done"}, done, 1);
    check({nm, "_cycles"}, n, exp_cycles);
    check({nm, "_reads"}, rd_idx, 256);
    check({nm, "_writes"}, wr_idx, 256);
    check({nm, "_aligns"}, aligns, exp_align);
    check({nm, "_halt_wait"}, halt_extra, delay);
    check({nm, "_first_rd_par"}, first_par, 0);
    check({nm, "_seq_err"}, seq_err, 0);
    check({nm, "_last_rd"}, last_rd, {page, 8'hFF});
    check({nm, "_end_own"}, bus_own, 0);
    check({nm, "_end_active"}, dma_active, 0);
  endtask

  initial begin
    int wcnt = 0;
    logic hit = 1'b0;

    rstn_in = 1'b0; cpu_addr = 16'h0; cpu_rnw = 1'b1; cpu_dout = 8'h0;
    cpu_halted = 1'b0; bus_din = 8'h0;
    #100;
    check("rst_rdy", cpu_rdy, 1);
    check("rst_own", bus_own, 0);
    check("rst_active", dma_active, 0);
    check("rst_addr", bus_addr, 16'h0000);
    check("rst_rnw", bus_rnw, 1);
    check("rst_dout", bus_dout, 8'h00);
    #10 rstn_in = 1'b1;
    tb_par = 1'b0;

    // A read of $4014 and a write elsewhere must not start a transfer
    cpu_addr = 16'h4014; cpu_rnw = 1'b1; cpu_dout = 8'h02;
    cpu_cycle();
    check("rd4014_rdy", cpu_rdy, 1);
    cpu_addr = 16'h4015; cpu_rnw = 1'b0;
    cpu_cycle();
    check("wr4015_rdy", cpu_rdy, 1);
    cpu_addr = 16'h0000; cpu_rnw = 1'b1;

    run_xfer("even", 8'h02, 1'b0, 0, 513, 0, 1'b0);
    run_xfer("odd",  8'h02, 1'b1, 0, 514, 1, 1'b0);
    run_xfer("data", 8'h03, 1'b0, 0, 513, 0, 1'b0);
    run_xfer("wrap", 8'hFF, 1'b0, 0, 513, 0, 1'b1);
    run_xfer("slow", 8'h02, 1'b0, 3, 517, 1, 1'b0);

    // Reset in the middle of the WRITE of index $40
    if (tb_par != 1'b0) cpu_cycle();
    cpu_addr = 16'h4014; cpu_rnw = 1'b0; cpu_dout = 8'h04;
    cpu_cycle();
    cpu_addr = 16'h0000; cpu_rnw = 1'b1; cpu_halted = 1'b1;
    for (int k = 0; k < 600 && !hit; k++) begin
      bus_din = (bus_own && bus_rnw) ? mem_rd(bus_addr) : 8'h00;
      cpu_cycle();
      if (bus_own && !bus_rnw) begin
        if (wcnt == 64) hit = 1'b1;
        else wcnt++;
      end
    end
    check("mid_reach", hit, 1);
    check("mid_dout", bus_dout, mem_rd(16'h0440));
    #5 rstn_in = 1'b0;
    #1;
    check("mid_rst_rdy", cpu_rdy, 1);
    check("mid_rst_own", bus_own, 0);
    check("mid_rst_active", dma_active, 0);
    check("mid_rst_rnw", bus_rnw, 1);
    check("mid_rst_addr", bus_addr, 16'h0000);
    cpu_halted = 1'b0;
    repeat (4) @(posedge clk);
    #5 rstn_in = 1'b1;
    tb_par = 1'b0;

    run_xfer("post_rst", 8'h05, 1'b0, 0, 513, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
